imem_loader: RTL
================

# imem_loader

Writer side of the instruction memory port: accepts a byte stream with a valid/ready handshake and assembles little-endian 32-bit words. It writes each word into consecutive instruction memory locations starting at address 0. The block sits between the program download path (UART/debug byte source) and the instruction memory write port, and fills the memory before the core starts fetching.

## Interface
- ADDR_WIDTH, 7, instruction memory word-address width (DEPTH = 2**ADDR_WIDTH = 128 words)
- DATA_WIDTH, 32, instruction word width (fixed at 4 bytes)

- clock  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- start  input  1  load request; sampled only in IDLE or DONE
- word_count  input  ADDR_WIDTH+1  number of words to load, 0..128; latched on accepted start
- byte_in  input  8  next program byte
- byte_valid  input  1  byte_in is valid
- byte_ready  output  1  loader accepts a byte this cycle
- WAdress  output  ADDR_WIDTH  memory write word address
- WData  output  DATA_WIDTH  memory write data
- WEnable  output  1  one-cycle write strobe
- busy  output  1  load in progress (RECV or WRITE)
- done  output  1  level; last load completed, held until next accepted start or reset

## Operation
- The FSM has four states: IDLE, RECV, WRITE, DONE.
- IDLE / DONE, start=1:
  - Latch word_count into words_left.
  - Clear addr and byte_idx to 0.
  - Clear done.
  - Go to RECV, or to DONE if word_count=0; no write is issued in that case.
- RECV:
  - byte_ready=1.
  - On byte_valid && byte_ready, load byte_in into lane byte_idx of the assembly register. Byte 0 goes to bits 7:0 and byte 3 to bits 31:24.
  - byte_idx increments on each accepted byte.
  - Acceptance of the 4th byte sends the FSM to WRITE.
- WRITE, exactly one cycle:
  - WEnable=1, WAdress=addr, WData=assembled word.
  - byte_ready=0.
  - Exit actions: addr+1, words_left-1, byte_idx=0.
  - Next state is DONE if the decremented words_left is 0, otherwise RECV.
- DONE: done=1, busy=0, byte_ready=0. Stays here until start.
- start while busy is ignored, with no effect on state, counters or done.
- byte_valid while byte_ready=0 is not consumed; the source must hold the byte.
- Address wrap: with word_count ≤ 128, the last write is at address 127. The addr increment wraps to 0 after the final write, but no further write occurs.
- word_count > 128 (bit 7 set with nonzero lower bits) is out of range. It is clamped to 128.
- Only WData/WAdress/WEnable drive the memory. WData and WAdress hold their last values outside WRITE, and their value when WEnable=0 is don't-care.

## Timing
- Reset values:
  - State IDLE.
  - byte_ready=0, WEnable=0, WAdress=0, WData=0, busy=0, done=0.
  - Internal addr, byte_idx, words_left and the assembly register are all 0.
- start sampled at edge E puts the FSM in RECV in the cycle after E, so byte_ready=1 in that cycle.
- Byte transfer occurs on every edge with byte_valid && byte_ready. Back-to-back bytes are accepted every cycle.
- 4th byte accepted at edge N: WEnable=1 during cycle N..N+1, and the memory captures the word on edge N+1.
- After edge N+1 the FSM is in RECV (byte_ready=1) or in DONE (done=1).
- Minimum is 5 cycles per word (4 RECV + 1 WRITE).
- A 128-word load with continuous bytes takes 640 cycles from the first RECV cycle to DONE.
- Reset asserted mid-load:
  - Any partial word is discarded and never written.
  - WEnable drops immediately, because reset is asynchronous.
  - The next start reloads from address 0.

## Test plan
- Reset: hold reset over several clocks with random inputs -> all outputs 0, no WEnable, byte_ready=0; release -> IDLE, outputs still 0.
- Single word: start, word_count=1, bytes 0x13,0x05,0x50,0x00 back-to-back -> exactly one WEnable pulse with WAdress=0 and WData=0x00500513; done=1 and busy=0 on the next cycle.
- Gaps and backpressure: word_count=3, byte_valid toggled randomly over bytes 0x01..0x0C -> writes at addresses 0,1,2 with data 0x04030201, 0x08070605, 0x0C0B0A09; no byte is consumed while byte_ready=0.
- Full memory: word_count=128, word k = k*0x01010101 -> 128 WEnable pulses, WAdress 0..127 in order, none after 127; done asserts; start during the load is ignored.
- Zero count: start with word_count=0 -> done=1 on the next cycle, WEnable never asserted, byte_ready never 1.
- Reset mid-word: word_count=2, reset asserted after 2 bytes of the first word -> no WEnable; after a new start with 0xDEADBEEF bytes EF,BE,AD,DE -> write at WAdress=0, WData=0xDEADBEEF.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader
// Fills the instruction memory from a byte stream before the core starts
// fetching. Bytes arrive over a valid/ready handshake. Each group of four is
// packed little-endian into a 32-bit word. Words are written to consecutive
// word addresses starting at 0.
//
// Ports:
//   clock       single clock, rising-edge
//   reset       asynchronous active-high reset
//   start       load request, honoured only in IDLE or DONE
//   word_count  words to load (0..DEPTH, larger values clamp to DEPTH)
//   byte_in     next program byte
//   byte_valid  byte_in is valid
//   byte_ready  loader takes a byte this cycle
//   WAdress     memory write word address
//   WData       memory write data
//   WEnable     one-cycle write strobe
//   busy        load in progress
//   done        last load completed; held until next accepted start
module imem_loader #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   word_count,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic [ADDR_WIDTH-1:0] WAdress,
  output logic [DATA_WIDTH-1:0] WData,
  output logic                  WEnable,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH:0] DEPTH_W = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   wordsLeft_q;
  logic [1:0]            byteIdx_q;
  logic [DATA_WIDTH-1:0] assembly_q;
  logic [DATA_WIDTH-1:0] wData_q;
  logic [ADDR_WIDTH-1:0] wAddr_q;

  logic                  idleOrDone;
  logic                  acceptStart;
  logic                  acceptByte;
  logic [ADDR_WIDTH:0]   countClamped;
  logic [ADDR_WIDTH:0]   wordsLeftDec;

  // Out-of-range counts would otherwise wrap the address and overwrite the
  // start of the program, so they saturate at a full memory.
  assign countClamped = (word_count > DEPTH_W) ? DEPTH_W : word_count;
  assign wordsLeftDec = wordsLeft_q - 1'b1;
  assign idleOrDone   = (state_q == IDLE) || (state_q == DONE);
  assign acceptStart  = idleOrDone && start;
  assign acceptByte   = (state_q == RECV) && byte_valid;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_ready = 1'b0;
    WEnable    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = (countClamped == '0) ? DONE : RECV;
      end
      RECV: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid && (byteIdx_q == 2'd3)) state_d = WRITE;
      end
      WRITE: begin
        WEnable = 1'b1;
        busy    = 1'b1;
        state_d = (wordsLeftDec == '0) ? DONE : RECV;
      end
      DONE: begin
        // done is derived from the state, so an accepted start clears it
        // on the same edge that leaves DONE.
        done = 1'b1;
        if (start) state_d = (countClamped == '0) ? DONE : RECV;
      end
      default: state_d = IDLE;
    endcase
  end

  // The write port is registered when the fourth byte lands, so WData and
  // WAdress stay stable during WRITE and hold afterwards while addr_q and
  // the assembly register move on to the next word.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q      <= '0;
      wordsLeft_q <= '0;
      byteIdx_q   <= '0;
      assembly_q  <= '0;
      wData_q     <= '0;
      wAddr_q     <= '0;
    end else begin
      if (acceptStart) begin
        wordsLeft_q <= countClamped;
        addr_q      <= '0;
        byteIdx_q   <= '0;
      end
      if (acceptByte) begin
        assembly_q[{byteIdx_q, 3'b000} +: 8] <= byte_in;
        byteIdx_q                            <= byteIdx_q + 2'd1;
        if (byteIdx_q == 2'd3) begin
          wData_q <= {byte_in, assembly_q[23:0]};
          wAddr_q <= addr_q;
        end
      end
      if (state_q == WRITE) begin
        addr_q      <= addr_q + 1'b1;
        wordsLeft_q <= wordsLeftDec;
        byteIdx_q   <= '0;
      end
    end
  end

  assign WData   = wData_q;
  assign WAdress = wAddr_q;

endmodule
